// File: rtl/conv_tile_feeder.sv
// Ping-pong 8x8 tile assembler feeding the 2D convolution core.
// A row-major pixel stream fills one bank while the other bank is held for the core.
module conv_tile_feeder #(
  parameter int IMG_W   = 8,
  parameter int PIX_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  input  logic [PIX_W-1:0]             s_data,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic [IMG_W*IMG_W*PIX_W-1:0] tile_data,
  output logic                         tile_start,
  input  logic                         conv_done,
  output logic                         frame_err,
  output logic                         timeout_err
);
  localparam int N  = IMG_W * IMG_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  logic [PIX_W-1:0] pix_reg [2][N];
  logic [1:0]       full_reg;
  logic             wr_bank_reg;
  logic             rd_bank_reg;
  logic [CW-1:0]    wr_cnt_reg;
  state_t           state_reg;
  logic [TW-1:0]    timer_reg;
  logic             tile_start_reg;
  logic             frame_err_reg;
  logic             timeout_err_reg;

  logic             wr_fire;
  logic             wr_wrap;
  logic             rd_release;
  logic [1:0]       full_set;
  logic [1:0]       full_clr;

  assign s_ready    = !full_reg[wr_bank_reg];
  assign wr_fire    = s_valid && s_ready;
  assign wr_wrap    = wr_fire && (wr_cnt_reg == CW'(N - 1));
  // Release on conv_done or on the last permitted WAIT cycle, whichever comes first.
  assign rd_release = (state_reg == WAIT) &&
                      (conv_done || (timer_reg == TW'(TIMEOUT - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          pix_reg[b][k] <= '0;
        end
      end
    end else if (wr_fire) begin
      pix_reg[wr_bank_reg][wr_cnt_reg] <= s_data;
    end
  end

  // A premature s_last drops the partial tile; a missing s_last still keeps the full tile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_reg    <= '0;
      wr_bank_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else if (wr_fire) begin
      if (wr_wrap) begin
        wr_cnt_reg  <= '0;
        wr_bank_reg <= !wr_bank_reg;
        if (!s_last) begin
          frame_err_reg <= 1'b1;
        end
      end else if (s_last) begin
        wr_cnt_reg    <= '0;
        frame_err_reg <= 1'b1;
      end else begin
        wr_cnt_reg <= wr_cnt_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign full_set[gi] = wr_wrap && (wr_bank_reg == 1'(gi));
    assign full_clr[gi] = rd_release && (rd_bank_reg == 1'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_reg <= '0;
    end else begin
      full_reg <= (full_reg | full_set) & ~full_clr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      rd_bank_reg     <= 1'b0;
      timer_reg       <= '0;
      tile_start_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tile_start_reg <= 1'b0;
          if (full_reg[rd_bank_reg]) begin
            state_reg      <= ISSUE;
            tile_start_reg <= 1'b1;
          end
        end
        ISSUE: begin
          tile_start_reg <= 1'b0;
          timer_reg      <= '0;
          state_reg      <= WAIT;
        end
        WAIT: begin
          tile_start_reg <= 1'b0;
          timer_reg      <= timer_reg + 1'b1;
          if (conv_done) begin
            rd_bank_reg <= !rd_bank_reg;
            state_reg   <= IDLE;
          end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            timeout_err_reg <= 1'b1;
            rd_bank_reg     <= !rd_bank_reg;
            state_reg       <= IDLE;
          end
        end
        default: begin
          tile_start_reg <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_tile
    assign tile_data[gi*PIX_W +: PIX_W] = pix_reg[rd_bank_reg][gi];
  end

  assign tile_start  = tile_start_reg;
  assign frame_err   = frame_err_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_conv_tile_feeder.sv
// Directed-plus-random bench for conv_tile_feeder with a tile-level queue model of the stream.
module tb_conv_tile_feeder;
  localparam int IMG_W   = 8;
  localparam int PIX_W   = 8;
  localparam int TIMEOUT = 80;  // longer than one tile fill so both banks can be held
  localparam int N       = IMG_W * IMG_W;
  localparam int TDW     = N * PIX_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic [PIX_W-1:0] s_data = '0;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic [TDW-1:0]   tile_data;
  logic             tile_start;
  logic             conv_done = 1'b0;
  logic             frame_err;
  logic             timeout_err;

  conv_tile_feeder #(.IMG_W(IMG_W), .PIX_W(PIX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .tile_data(tile_data), .tile_start(tile_start),
    .conv_done(conv_done), .frame_err(frame_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [PIX_W-1:0] pix_q [$];
  logic [TDW-1:0]   exp_tiles [$];
  logic [TDW-1:0]   cur_tile = '0;
  int  held = 0;
  bit  waiting = 0;
  int  wait_cnt = 0;
  int  done_delay = 3;   // 0 means the core never answers
  int  spur_pct = 0;
  bit  exp_ferr = 0;
  bit  exp_terr = 0;
  bit  last_hs = 0;
  bit  saw_stall = 0;
  int  complete_cyc = -1;
  int  start_cyc = -1;
  int  n_issued = 0;

  task automatic chk(input string tag, input logic [TDW-1:0] got, input logic [TDW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TDW-1:0] pack_tile();
    logic [TDW-1:0] t = '0;
    for (int k = 0; k < N; k++) t[k*PIX_W +: PIX_W] = pix_q[k];
    return t;
  endfunction

  task automatic tick();
    bit hs, cd, lst;
    logic [PIX_W-1:0] d;
    logic [1:0] st;
    @(negedge clk);
    hs = s_valid && s_ready;
    cd = conv_done;
    lst = s_last;
    d = s_data;
    @(posedge clk);
    #1;
    cyc++;
    last_hs = hs;
    if (hs) begin
      pix_q.push_back(d);
      if (pix_q.size() == N) begin
        exp_tiles.push_back(pack_tile());
        held++;
        complete_cyc = cyc;
        if (!lst) exp_ferr = 1;
        pix_q.delete();
      end else if (lst) begin
        exp_ferr = 1;
        pix_q.delete();
      end
    end
    if (tile_start) begin
      st = {waiting, exp_tiles.size() != 0};
      chk("start_expected", st, 2'b01);
      if (exp_tiles.size() != 0) begin
        cur_tile = exp_tiles.pop_front();
        chk("tile_data", tile_data, cur_tile);
      end
      waiting = 1;
      wait_cnt = 0;
      start_cyc = cyc;
      n_issued++;
      $display("tile %0d issued at cycle %0d", n_issued, cyc);
    end else if (waiting) begin
      wait_cnt++;
      if (cd) begin
        waiting = 0;
        held--;
      end else if (wait_cnt == TIMEOUT + 1) begin
        waiting = 0;
        held--;
        exp_terr = 1;
      end else begin
        chk("tile_hold", tile_data, cur_tile);
      end
    end
    chk("s_ready", s_ready, held < 2);
    chk("frame_err", frame_err, exp_ferr);
    chk("timeout_err", timeout_err, exp_terr);
    if (!s_ready) saw_stall = 1;
    conv_done = 1'b0;
    if (waiting && done_delay > 0 && wait_cnt == done_delay) conv_done = 1'b1;
    else if (!waiting && spur_pct > 0 && $urandom_range(99) < spur_pct) conv_done = 1'b1;
  endtask

  task automatic send_pix(input logic [PIX_W-1:0] d, input bit last, input int gap_pct);
    int guard = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      s_valid = 1'b0;
      s_last = 1'b0;
      tick();
    end
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    do begin
      tick();
      guard++;
    end while (!last_hs && guard < 500);
    if (!last_hs) chk("handshake_bound", 0, 1);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_tile(input int n, input int last_at, input int gap_pct, input bit ramp);
    for (int i = 0; i < n; i++) begin
      send_pix(ramp ? PIX_W'(i - 32) : PIX_W'($urandom), i == last_at, gap_pct);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((held > 0 || waiting || exp_tiles.size() != 0) && guard < 3000) begin
      tick();
      guard++;
    end
    chk("drain_bound", (held == 0 && !waiting), 1);
    repeat (4) tick();
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    conv_done = 1'b0;
    #1;
    chk("rst_tile_start", tile_start, 0);
    chk("rst_tile_data", tile_data, '0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_timeout_err", timeout_err, 0);
    pix_q.delete();
    exp_tiles.delete();
    held = 0;
    waiting = 0;
    wait_cnt = 0;
    exp_ferr = 0;
    exp_terr = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int base;
    int guard;
    logic [PIX_W-1:0] b0;
    logic [PIX_W-1:0] b63;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tile_start", tile_start, 0);
    chk("reset_tile_data", tile_data, '0);
    chk("reset_s_ready", s_ready, 1);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_timeout_err", timeout_err, 0);
    rst = 1'b0;
    repeat (2) tick();

    // 1: ramp tile, issue latency and contents
    done_delay = 3;
    send_tile(N, N - 1, 0, 1'b1);
    chk("latency_pre", tile_start, 0);
    tick();
    chk("latency_start", tile_start, 1);
    chk("issue_latency", start_cyc - complete_cyc, 1);
    b0 = tile_data[PIX_W-1:0];
    b63 = tile_data[(N-1)*PIX_W +: PIX_W];
    chk("ramp_first", b0, 8'hE0);
    chk("ramp_last", b63, 8'h1F);
    drain();

    // 2: three back-to-back tiles, slow core answering on the last allowed cycle
    done_delay = TIMEOUT;
    saw_stall = 0;
    base = n_issued;
    repeat (3) send_tile(N, N - 1, 0, 1'b0);
    drain();
    chk("stall_seen", saw_stall, 1);
    chk("b2b_issued", n_issued - base, 3);
    chk("b2b_no_timeout", timeout_err, 0);

    // 3: early s_last discards the partial tile
    done_delay = 4;
    base = n_issued;
    send_tile(11, 10, 0, 1'b0);
    repeat (10) tick();
    chk("early_last_no_issue", n_issued - base, 0);
    send_tile(N, N - 1, 0, 1'b0);
    drain();
    chk("after_err_issued", n_issued - base, 1);

    // 4: core never answers, both tiles released by timeout
    done_delay = 0;
    base = n_issued;
    repeat (2) send_tile(N, N - 1, 0, 1'b0);
    drain();
    chk("timeout_flag", timeout_err, 1);
    chk("timeout_issued", n_issued - base, 2);

    // 5: random gaps, random core delay, spurious conv_done outside WAIT
    spur_pct = 20;
    base = n_issued;
    for (int t = 0; t < 4; t++) begin
      done_delay = $urandom_range(20, 1);
      send_tile(N, N - 1, 30, 1'b0);
    end
    drain();
    spur_pct = 0;
    chk("random_issued", n_issued - base, 4);

    // 6: reset mid-tile and mid-WAIT
    done_delay = 0;
    send_tile(40, -1, 0, 1'b0);
    do_reset();
    repeat (5) tick();
    send_tile(N, N - 1, 0, 1'b0);
    guard = 0;
    while (!waiting && guard < 200) begin
      tick();
      guard++;
    end
    chk("reach_wait", waiting, 1);
    repeat (5) tick();
    do_reset();
    repeat (8) tick();
    done_delay = 5;
    base = n_issued;
    send_tile(N, N - 1, 0, 1'b1);
    drain();
    chk("post_reset_issued", n_issued - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
